// File: rtl/sent_div_arbiter.sv
// Round-robin arbiter sharing one pipelined divider among NUM_REQ requesters; results are routed back via an in-order tag FIFO.
// Optional SENT_DIV_ROUND_EN: issue dividend + divisor/2 for a round-to-nearest quotient.
module sent_div_arbiter #(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned MAX_OUTSTANDING = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [32*NUM_REQ-1:0]   req_dividend,
  input  logic [32*NUM_REQ-1:0]   req_divisor,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [31:0]             rsp_quotient,
  output logic [31:0]             rsp_remainder,
  output logic                    div_divisor_tvalid,
  output logic                    div_dividend_tvalid,
  output logic [31:0]             div_divisor_tdata,
  output logic [31:0]             div_dividend_tdata,
  input  logic                    div_dout_tvalid,
  input  logic [63:0]             div_dout_tdata,
  output logic                    err_orphan
);

  localparam int unsigned TW = $clog2(NUM_REQ);
  localparam int unsigned AW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CW = AW + 1;

  logic [TW-1:0]        rr_q, rr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [AW-1:0]        wr_q, rd_q;
  logic [TW-1:0]        tag_mem_q [MAX_OUTSTANDING];
  logic [NUM_REQ-1:0]   rsp_valid_q;
  logic [31:0]          rsp_quot_q, rsp_rem_q;
  logic                 div_tvalid_q;
  logic [31:0]          div_dvd_q, div_dvs_q;
  logic                 err_q;

  logic [TW-1:0]        cand;
  logic [TW-1:0]        sel_idx;
  logic                 sel_found;
  logic                 can_issue;
  logic                 accept;
  logic                 pop;
  logic                 orphan;
  logic [31:0]          sel_dividend, sel_divisor, issue_dividend;

  // First valid requester at or after rr_q, wrapping.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = TW'((32'(rr_q) + k) % NUM_REQ);
      if (!sel_found && req_valid[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // Ready comes from the registered count only, so a same-cycle pop never frees a slot.
  assign can_issue = (cnt_q < CW'(MAX_OUTSTANDING));
  assign accept    = sel_found && can_issue && !rst;
  assign req_ready = accept ? (NUM_REQ'(1) << sel_idx) : '0;

  assign pop    = div_dout_tvalid && (cnt_q != '0);
  assign orphan = div_dout_tvalid && (cnt_q == '0);

  assign sel_dividend = req_dividend[32*sel_idx +: 32];
  assign sel_divisor  = req_divisor[32*sel_idx +: 32];

`ifdef SENT_DIV_ROUND_EN
  assign issue_dividend = sel_dividend + (sel_divisor >> 1);
`else
  assign issue_dividend = sel_dividend;
`endif

  always_comb begin
    rr_d = rr_q;
    if (accept) begin
      rr_d = (sel_idx == TW'(NUM_REQ - 1)) ? '0 : sel_idx + TW'(1);
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({accept, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q         <= '0;
      cnt_q        <= '0;
      wr_q         <= '0;
      rd_q         <= '0;
      rsp_valid_q  <= '0;
      rsp_quot_q   <= '0;
      rsp_rem_q    <= '0;
      div_tvalid_q <= 1'b0;
      div_dvd_q    <= '0;
      div_dvs_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      rr_q         <= rr_d;
      cnt_q        <= cnt_d;
      div_tvalid_q <= accept;
      if (accept) begin
        div_dvd_q <= issue_dividend;
        div_dvs_q <= sel_divisor;
        wr_q      <= wr_q + AW'(1);
      end
      if (pop) begin
        rsp_valid_q <= NUM_REQ'(1) << tag_mem_q[rd_q];
        rsp_quot_q  <= div_dout_tdata[63:32];
        rsp_rem_q   <= div_dout_tdata[31:0];
        rd_q        <= rd_q + AW'(1);
      end else begin
        rsp_valid_q <= '0;
      end
      if (orphan) begin
        err_q <= 1'b1;
      end
    end
  end

  // Tag storage needs no reset: occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (accept) begin
      tag_mem_q[wr_q] <= sel_idx;
    end
  end

  assign rsp_valid           = rsp_valid_q;
  assign rsp_quotient        = rsp_quot_q;
  assign rsp_remainder       = rsp_rem_q;
  assign div_divisor_tvalid  = div_tvalid_q;
  assign div_dividend_tvalid = div_tvalid_q;
  assign div_divisor_tdata   = div_dvs_q;
  assign div_dividend_tdata  = div_dvd_q;
  assign err_orphan          = err_q;

endmodule
